// File: rtl/capture_ring_ctrl.sv
// Capture-path write-address sequencer: carves captured beats into AXI4 INCR bursts into a host ring.
// Define CAPTURE_RING_STATS_EN to build the stat_* counters; otherwise those ports read constant 0.
module capture_ring_ctrl #(
    parameter int         ADDR_WIDTH      = 32,
    parameter int         DATA_WIDTH      = 512,
    parameter int         MAX_BURST       = 16,
    parameter int         PTR_WIDTH       = 20,
    parameter int         MAX_OUTSTANDING = 4,
    parameter logic [5:0] AWID            = 6'd0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [4:0]            cfg_ring_log2,
    input  logic                  cfg_start,
    input  logic                  cfg_stop,
    input  logic [PTR_WIDTH:0]    sw_tail,
    input  logic                  in_beat,
    output logic [5:0]            m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [7:0]            cmd_len,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [PTR_WIDTH:0]    head_ptr,
    output logic                  active,
    output logic                  done,
    output logic                  err,
    output logic                  ring_full,
    output logic [31:0]           stat_bursts,
    output logic [31:0]           stat_beats,
    output logic [31:0]           stat_full_cycles,
    output logic [15:0]           stat_berr
);
    localparam int PW        = PTR_WIDTH + 1;
    localparam int BPB_LOG2  = $clog2(DATA_WIDTH / 8);
    localparam int OUT_W     = $clog2(MAX_OUTSTANDING + 1);
    localparam int IDX_W     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [PW-1:0]    ONE      = PW'(1);
    localparam logic [PW-1:0]    ZERO     = {PW{1'b0}};
    localparam logic [PW-1:0]    SAT      = {PW{1'b1}};
    localparam logic [PW-1:0]    MB       = PW'(MAX_BURST);
    localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(MAX_OUTSTANDING);
    localparam logic [OUT_W-1:0] OUT_ONE  = OUT_W'(1);
    localparam logic [OUT_W-1:0] OUT_ZERO = {OUT_W{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic [PW-1:0] min_ptr(input logic [PW-1:0] a, input logic [PW-1:0] b);
        min_ptr = (a < b) ? a : b;
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(MAX_OUTSTANDING - 1)) begin
            next_idx = {IDX_W{1'b0}};
        end else begin
            next_idx = idx + IDX_W'(1);
        end
    endfunction

    state_t                  state_r, state_nxt_s;
    logic [ADDR_WIDTH-1:0]   base_r, awaddr_r;
    logic [4:0]              log2_r;
    logic [PW-1:0]           issue_ptr_r, head_ptr_r, avail_r, avail_nxt_s, avail_dec_s;
    logic [OUT_W-1:0]        outstanding_r;
    logic [7:0]              awlen_r;
    logic                    awvalid_r, cmd_valid_r, err_r, bready_r;
    logic                    ring_full_r, active_r, done_r;
    logic [7:0]              len_fifo_r [MAX_OUTSTANDING];
    logic [IDX_W-1:0]        wr_idx_r, rd_idx_r;

    logic [PW-1:0] ring_s, mask_s, offset_s, diff_s, free_s, burst_room_s, ring_room_s, len_s, head_beats_s;
    logic          full_s, in_flight_s, launch_s, aw_hs_s, cmd_hs_s, b_ack_s, b_err_s;
    logic          beat_in_s, start_ok_s, drained_s;

    // Pointers live modulo 2*ring so bit cfg_ring_log2 acts as the wrap bit.
    assign ring_s       = ONE << log2_r;
    assign mask_s       = (ring_s << 1) - ONE;
    assign offset_s     = issue_ptr_r & (ring_s - ONE);
    assign diff_s       = (issue_ptr_r - sw_tail) & mask_s;
    assign full_s       = (diff_s == ring_s);
    assign free_s       = ring_s - diff_s;
    assign burst_room_s = MB - (issue_ptr_r & (MB - ONE));
    assign ring_room_s  = ring_s - offset_s;
    assign len_s        = min_ptr(min_ptr(avail_r, burst_room_s), min_ptr(ring_room_s, free_s));

    assign in_flight_s  = (state_r == S_RUN) || (state_r == S_FLUSH);
    assign start_ok_s   = cfg_start && ((state_r == S_IDLE) || (state_r == S_DONE));
    assign launch_s     = in_flight_s && !awvalid_r && !cmd_valid_r && (outstanding_r < OUT_MAX)
                          && (avail_r != ZERO) && !full_s;
    assign aw_hs_s      = awvalid_r && m_axi_awready;
    assign cmd_hs_s     = cmd_valid_r && cmd_ready;
    assign b_ack_s      = m_axi_bvalid && bready_r && (outstanding_r != OUT_ZERO);
    assign b_err_s      = b_ack_s && (m_axi_bresp != 2'b00);
    assign beat_in_s    = in_beat && in_flight_s;
    assign head_beats_s = PW'(len_fifo_r[rd_idx_r]) + ONE;
    assign drained_s    = (avail_r == ZERO) && !awvalid_r && !cmd_valid_r && (outstanding_r == OUT_ZERO);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE:  if (cfg_start) state_nxt_s = S_RUN; else state_nxt_s = S_IDLE;
            S_RUN:   if (cfg_stop || err_r || b_err_s) state_nxt_s = S_FLUSH; else state_nxt_s = S_RUN;
            S_FLUSH: if (drained_s) state_nxt_s = S_DONE; else state_nxt_s = S_FLUSH;
            S_DONE:  if (cfg_start) state_nxt_s = S_RUN; else state_nxt_s = S_DONE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Beat accounting: launch debit first, then saturating credit for the incoming beat.
    always_comb begin
        avail_dec_s = avail_r;
        if (launch_s) begin
            avail_dec_s = avail_r - len_s;
        end else begin
            avail_dec_s = avail_r;
        end
        if (beat_in_s && (avail_dec_s != SAT)) begin
            avail_nxt_s = avail_dec_s + ONE;
        end else begin
            avail_nxt_s = avail_dec_s;
        end
    end

    // Burst issue, AW/cmd handshakes, B tracking and pointer bookkeeping.
    always_ff @(posedge clk) begin
        if (rst || start_ok_s) begin
            issue_ptr_r   <= ZERO;
            head_ptr_r    <= ZERO;
            avail_r       <= ZERO;
            outstanding_r <= OUT_ZERO;
            awvalid_r     <= 1'b0;
            cmd_valid_r   <= 1'b0;
            err_r         <= 1'b0;
            wr_idx_r      <= {IDX_W{1'b0}};
            rd_idx_r      <= {IDX_W{1'b0}};
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                len_fifo_r[i] <= 8'd0;
            end
            if (rst) begin
                base_r   <= {ADDR_WIDTH{1'b0}};
                log2_r   <= 5'd0;
                awaddr_r <= {ADDR_WIDTH{1'b0}};
                awlen_r  <= 8'd0;
                bready_r <= 1'b0;
            end else begin
                base_r   <= cfg_base_addr;
                log2_r   <= cfg_ring_log2;
                bready_r <= 1'b1;
            end
        end else begin
            bready_r <= 1'b1;
            avail_r  <= avail_nxt_s;
            if (launch_s) begin
                issue_ptr_r          <= (issue_ptr_r + len_s) & mask_s;
                awaddr_r             <= base_r + (ADDR_WIDTH'(offset_s) << BPB_LOG2);
                awlen_r              <= 8'(len_s - ONE);
                awvalid_r            <= 1'b1;
                cmd_valid_r          <= 1'b1;
                len_fifo_r[wr_idx_r] <= 8'(len_s - ONE);
                wr_idx_r             <= next_idx(wr_idx_r);
            end else begin
                if (aw_hs_s) awvalid_r <= 1'b0;
                if (cmd_hs_s) cmd_valid_r <= 1'b0;
            end
            case ({aw_hs_s, b_ack_s})
                2'b10:   outstanding_r <= outstanding_r + OUT_ONE;
                2'b01:   outstanding_r <= outstanding_r - OUT_ONE;
                default: outstanding_r <= outstanding_r;
            endcase
            if (b_ack_s) begin
                head_ptr_r <= (head_ptr_r + head_beats_s) & mask_s;
                rd_idx_r   <= next_idx(rd_idx_r);
            end
            if (b_err_s) err_r <= 1'b1;
        end
    end

    // Registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ring_full_r <= 1'b0;
            active_r    <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            ring_full_r <= full_s;
            active_r    <= (state_nxt_s == S_RUN) || (state_nxt_s == S_FLUSH);
            done_r      <= (state_nxt_s == S_DONE);
        end
    end

    assign m_axi_awid    = AWID;
    assign m_axi_awaddr  = awaddr_r;
    assign m_axi_awlen   = awlen_r;
    assign m_axi_awsize  = 3'(BPB_LOG2);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awvalid = awvalid_r;
    assign m_axi_bready  = bready_r;
    assign cmd_len       = awlen_r;
    assign cmd_valid     = cmd_valid_r;
    assign head_ptr      = head_ptr_r;
    assign active        = active_r;
    assign done          = done_r;
    assign err           = err_r;
    assign ring_full     = ring_full_r;

`ifdef CAPTURE_RING_STATS_EN
    logic [31:0] stat_bursts_r, stat_beats_r, stat_full_cycles_r;
    logic [15:0] stat_berr_r;

    // Free-running event counters, wrapping at full scale.
    always_ff @(posedge clk) begin
        if (rst || start_ok_s) begin
            stat_bursts_r      <= 32'd0;
            stat_beats_r       <= 32'd0;
            stat_full_cycles_r <= 32'd0;
            stat_berr_r        <= 16'd0;
        end else begin
            if (aw_hs_s) stat_bursts_r <= stat_bursts_r + 32'd1;
            if (b_ack_s) stat_beats_r <= stat_beats_r + 32'(head_beats_s);
            if ((state_r == S_RUN) && full_s && (avail_r != ZERO)) stat_full_cycles_r <= stat_full_cycles_r + 32'd1;
            if (b_err_s) stat_berr_r <= stat_berr_r + 16'd1;
        end
    end

    assign stat_bursts      = stat_bursts_r;
    assign stat_beats       = stat_beats_r;
    assign stat_full_cycles = stat_full_cycles_r;
    assign stat_berr        = stat_berr_r;
`else
    assign stat_bursts      = 32'd0;
    assign stat_beats       = 32'd0;
    assign stat_full_cycles = 32'd0;
    assign stat_berr        = 16'd0;
`endif

endmodule
